// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the write port of one 8-bit FIFO between REQUESTERS producers.
// Define FIFO_ARB_BURST_EN to let a winner keep the grant for up to BURST_LEN consecutive writes.
module fifo_write_arbiter #(
   parameter int REQUESTERS = 4,
   parameter int BURST_LEN  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [REQUESTERS-1:0]         in_req,
   input  logic [8*REQUESTERS-1:0]       in_data,
   input  logic                          in_fifo_is_full,
   output logic [REQUESTERS-1:0]         out_gnt,
   output logic                          out_fifo_write_ctrl,
   output logic [7:0]                    out_fifo_write_data,
   output logic [$clog2(REQUESTERS)-1:0] out_owner,
   output logic                          out_busy
);

   localparam int PTR_W = $clog2(REQUESTERS);
   typedef logic [PTR_W-1:0] ptr_t;

   if (REQUESTERS < 2 || REQUESTERS > 16 || BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_params
      $error("fifo_write_arbiter: parameter out of range");
   end

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(REQUESTERS - 1)) ? '0 : ptr_t'(p + 1'b1);
   endfunction

   function automatic logic [REQUESTERS-1:0] onehot(input ptr_t p);
      return {{(REQUESTERS-1){1'b0}}, 1'b1} << p;
   endfunction

   // Returns {found, index} of the first requester at or after start, wrapping.
   function automatic logic [PTR_W:0] find_first(input logic [REQUESTERS-1:0] req, input ptr_t start);
      logic found;
      ptr_t idx_win;
      int   idx;
      found   = 1'b0;
      idx_win = '0;
      for (int k = 0; k < REQUESTERS; k++) begin
         idx = int'(start) + k;
         if (idx >= REQUESTERS) idx -= REQUESTERS;
         if (!found && req[ptr_t'(idx)]) begin
            found   = 1'b1;
            idx_win = ptr_t'(idx);
         end
      end
      return {found, idx_win};
   endfunction

   ptr_t                  rr_ptr, rr_ptr_n, owner_n, base, win;
   logic                  found;
   logic [REQUESTERS-1:0] gnt_c;

`ifdef FIFO_ARB_BURST_EN
   typedef enum logic {IDLE, BURST} state_t;
   state_t     state, state_n;
   logic [7:0] burst_cnt, burst_cnt_n;
   logic       search_en;

   // NOTE: every variable gets a default before any branch, otherwise a latch is inferred.
   always_comb begin
      state_n     = state;
      burst_cnt_n = burst_cnt;
      rr_ptr_n    = rr_ptr;
      owner_n     = out_owner;
      gnt_c       = '0;
      base        = rr_ptr;
      search_en   = 1'b1;

      if (state == BURST) begin
         if (in_fifo_is_full) begin
            search_en = 1'b0;
         end else if (in_req[out_owner]) begin
            search_en = 1'b0;
            gnt_c     = onehot(out_owner);
            if (burst_cnt == 8'(BURST_LEN - 1)) begin
               state_n     = IDLE;
               burst_cnt_n = '0;
               rr_ptr_n    = ptr_inc(out_owner);
            end else begin
               burst_cnt_n = burst_cnt + 1'b1;
            end
         end else begin
            // Owner dropped its request: close the burst and re-arbitrate this same cycle.
            state_n     = IDLE;
            burst_cnt_n = '0;
            base        = ptr_inc(out_owner);
            rr_ptr_n    = base;
         end
      end

      {found, win} = find_first(in_req, base);
      if (search_en && found && !in_fifo_is_full) begin
         gnt_c   = onehot(win);
         owner_n = win;
         if (BURST_LEN > 1) begin
            state_n     = BURST;
            burst_cnt_n = 8'd1;
         end else begin
            rr_ptr_n = ptr_inc(win);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         burst_cnt <= '0;
         rr_ptr    <= '0;
         out_owner <= '0;
      end else begin
         state     <= state_n;
         burst_cnt <= burst_cnt_n;
         rr_ptr    <= rr_ptr_n;
         out_owner <= owner_n;
      end
   end

   assign out_busy = (state == BURST);
`else
   always_comb begin
      rr_ptr_n     = rr_ptr;
      owner_n      = out_owner;
      gnt_c        = '0;
      base         = rr_ptr;
      {found, win} = find_first(in_req, base);
      if (found && !in_fifo_is_full) begin
         gnt_c    = onehot(win);
         owner_n  = win;
         rr_ptr_n = ptr_inc(win);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr    <= '0;
         out_owner <= '0;
      end else begin
         rr_ptr    <= rr_ptr_n;
         out_owner <= owner_n;
      end
   end

   assign out_busy = 1'b0;
`endif

   // Reset gates the grant combinationally so nothing reaches the FIFO once rst falls.
   always_comb begin
      out_gnt             = rst ? gnt_c : '0;
      out_fifo_write_ctrl = |out_gnt;
      out_fifo_write_data = '0;
      for (int k = 0; k < REQUESTERS; k++) begin
         if (out_gnt[k]) out_fifo_write_data = out_fifo_write_data | in_data[8*k +: 8];
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed vector tables, reset corner cases,
// and randomized traffic against a queue-free integer reference model.
module tb_fifo_write_arbiter;

   localparam int N  = 4;
   localparam int BL = 4;
`ifdef FIFO_ARB_BURST_EN
   localparam bit BURST_MODE = 1'b1;
`else
   localparam bit BURST_MODE = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [8*N-1:0] data;
   logic           full;
   logic [N-1:0]   gnt;
   logic           wr;
   logic [7:0]     wdata;
   logic [1:0]     owner;
   logic           busy;

   fifo_write_arbiter #(.REQUESTERS(N), .BURST_LEN(BL)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .in_req              (req),
      .in_data             (data),
      .in_fifo_is_full     (full),
      .out_gnt             (gnt),
      .out_fifo_write_ctrl (wr),
      .out_fifo_write_data (wdata),
      .out_owner           (owner),
      .out_busy            (busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: the arbitration rules in plain integer form.
   int m_ptr, m_owner, m_cnt;
   bit m_burst;

   task automatic model_reset();
      m_ptr = 0; m_owner = 0; m_cnt = 0; m_burst = 1'b0;
   endtask

   // Returns the winner this cycle (-1 for none) and advances the model to post-edge state.
   task automatic model_cycle(input logic [N-1:0] r, input bit f, output int w);
      int  start;
      bit  done;
      w    = -1;
      done = 1'b0;
      if (f) return;
      start = m_ptr;
      if (m_burst) begin
         if (r[m_owner]) begin
            w = m_owner;
            m_cnt = m_cnt + 1;
            if (m_cnt == BL) begin
               m_burst = 1'b0; m_cnt = 0; m_ptr = (m_owner + 1) % N;
            end
            return;
         end
         m_burst = 1'b0; m_cnt = 0; m_ptr = (m_owner + 1) % N;
         start = m_ptr;
      end
      for (int k = 0; k < N; k++) begin
         if (!done && r[(start + k) % N]) begin
            w = (start + k) % N;
            done = 1'b1;
         end
      end
      if (w >= 0) begin
         m_owner = w;
         if (BURST_MODE && BL > 1) begin
            m_burst = 1'b1; m_cnt = 1;
         end else begin
            m_ptr = (w + 1) % N;
         end
      end
   endtask

   typedef struct {
      logic [N-1:0] req;
      bit           full;
      logic [N-1:0] gnt;
      int           owner;
      bit           busy;
   } vec_t;

   vec_t vecs[$];
   vec_t dummy;

   // One clock: drive at posedge+1, compare at posedge+2, then advance past the next edge.
   task automatic cycle(input logic [N-1:0] r, input bit f, input string tag,
                        input bit use_tbl, input vec_t v);
      int           w;
      logic [N-1:0] eg;
      logic [7:0]   ed;
      int           eo;
      bit           eb;
      req  = r;
      full = f;
      data = $urandom;
      eo   = m_owner;
      eb   = m_burst;
      model_cycle(r, f, w);
      eg = (w < 0) ? '0 : (N'(1) << w);
      if (use_tbl) begin
         eg = v.gnt; eo = v.owner; eb = v.busy;
      end
      ed = '0;
      for (int k = 0; k < N; k++) if (eg[k]) ed = data[8*k +: 8];
      #1;
      check({tag, " gnt"},   32'(gnt),   32'(eg));
      check({tag, " wr"},    32'(wr),    32'(|eg));
      check({tag, " data"},  32'(wdata), 32'(ed));
      check({tag, " owner"}, 32'(owner), 32'(eo));
      check({tag, " busy"},  32'(busy),  32'(eb));
      @(posedge clk);
      #1;
   endtask

   initial begin
      dummy = '{'0, 1'b0, '0, 0, 1'b0};
`ifdef FIFO_ARB_BURST_EN
      for (int i = 0; i < 4; i++) vecs.push_back('{4'b0011, 1'b0, 4'b0001, 0, (i != 0)});
      vecs.push_back('{4'b0011, 1'b0, 4'b0010, 0, 1'b0});
      for (int i = 0; i < 3; i++) vecs.push_back('{4'b0011, 1'b0, 4'b0010, 1, 1'b1});
      vecs.push_back('{4'b0011, 1'b0, 4'b0001, 1, 1'b0});
      vecs.push_back('{4'b0011, 1'b0, 4'b0001, 0, 1'b1});
      vecs.push_back('{4'b0010, 1'b0, 4'b0010, 0, 1'b1});
      vecs.push_back('{4'b0010, 1'b1, 4'b0000, 1, 1'b1});
      vecs.push_back('{4'b0010, 1'b0, 4'b0010, 1, 1'b1});
`else
      for (int i = 0; i < 8; i++)
         vecs.push_back('{4'b1111, 1'b0, N'(1) << (i % 4), (i == 0) ? 0 : (i - 1) % 4, 1'b0});
      vecs.push_back('{4'b0110, 1'b0, 4'b0010, 3, 1'b0});
      vecs.push_back('{4'b0110, 1'b1, 4'b0000, 1, 1'b0});
      vecs.push_back('{4'b0110, 1'b1, 4'b0000, 1, 1'b0});
      vecs.push_back('{4'b0110, 1'b0, 4'b0100, 1, 1'b0});
      vecs.push_back('{4'b0001, 1'b0, 4'b0001, 2, 1'b0});
      vecs.push_back('{4'b1001, 1'b0, 4'b1000, 0, 1'b0});
      vecs.push_back('{4'b0000, 1'b0, 4'b0000, 3, 1'b0});
      vecs.push_back('{4'b0100, 1'b0, 4'b0100, 3, 1'b0});
      vecs.push_back('{4'b0100, 1'b0, 4'b0100, 2, 1'b0});
`endif

      // Reset held with all requests up: nothing may be granted.
      rst  = 1'b0;
      req  = 4'b1111;
      full = 1'b0;
      data = 32'h44332211;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst gnt",   32'(gnt),   32'h0);
      check("rst wr",    32'(wr),    32'h0);
      check("rst data",  32'(wdata), 32'h0);
      check("rst owner", 32'(owner), 32'h0);
      check("rst busy",  32'(busy),  32'h0);
      rst = 1'b1;
      #1;

      for (int i = 0; i < vecs.size(); i++)
         cycle(vecs[i].req, vecs[i].full, $sformatf("vec%0d", i), 1'b1, vecs[i]);

      // Asynchronous reset between edges, after a grant that opens a burst in the burst build.
      cycle(4'b0100, 1'b0, "pre_rst", 1'b0, dummy);
      req  = 4'b1111;
      full = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check("midrst gnt",   32'(gnt),   32'h0);
      check("midrst wr",    32'(wr),    32'h0);
      check("midrst data",  32'(wdata), 32'h0);
      check("midrst owner", 32'(owner), 32'h0);
      check("midrst busy",  32'(busy),  32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      cycle(4'b1111, 1'b0, "post_rst", 1'b1, '{4'b1111, 1'b0, 4'b0001, 0, 1'b0});

      // Randomized traffic with occasional full stalls.
      for (int i = 0; i < 400; i++)
         cycle(N'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
               $sformatf("rnd%0d", i), 1'b0, dummy);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
